// File: rtl/ctrl_sched.sv
// ctrl_sched: round-robin arbiter that shares one datapath command port.
// Ports: req_valid_i/req_cmd_i/req_ready_o (requesters), rsp_valid_o/
// rsp_err_o (one-hot response), cmd_valid_o/cmd_o/cmd_ready_i plus
// done_i/err_i (datapath), busy_o, grant_id_o (current/last grant).
// Optional macro CTRL_SCHED_TIMEOUT_EN adds a WAIT-state watchdog.
`timescale 1ns/1ps
module ctrl_sched #(
   parameter int N_REQ          = 4,
   parameter int CMD_W          = 8,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid_i,
   input  logic [N_REQ*CMD_W-1:0] req_cmd_i,
   output logic [N_REQ-1:0]       req_ready_o,
   output logic [N_REQ-1:0]       rsp_valid_o,
   output logic                   rsp_err_o,
   output logic                   cmd_valid_o,
   output logic [CMD_W-1:0]       cmd_o,
   input  logic                   cmd_ready_i,
   input  logic                   done_i,
   input  logic                   err_i,
   output logic                   busy_o,
   output logic [ID_W-1:0]        grant_id_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [ID_W-1:0]  rr_q;
   logic [ID_W-1:0]  id_q;
   logic [CMD_W-1:0] cmd_q;
   logic             err_q;

   logic             gnt_found;
   logic [ID_W-1:0]  gnt_idx;
   logic [ID_W-1:0]  rr_nxt;
   logic             tmo_hit;
   logic             op_end;

   // Search from rr_q upward with wrap; first valid requester wins.
   always_comb begin
      int k;
      k         = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         k = int'(rr_q) + i;
         if (k >= N_REQ)
            k = k - N_REQ;
         if (!gnt_found && req_valid_i[k]) begin
            gnt_found = 1'b1;
            gnt_idx   = ID_W'(k);
         end
      end
   end

   // Wrap explicitly so non-power-of-two N_REQ stays in range.
   assign rr_nxt = (gnt_idx == ID_W'(N_REQ - 1)) ?
                   '0 : gnt_idx + 1'b1;

`ifdef CTRL_SCHED_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_q;

   // Cleared throughout ISSUE, so it is zero on WAIT entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tmo_q <= '0;
      else if (state_q == S_ISSUE)
         tmo_q <= '0;
      else if (state_q == S_WAIT)
         tmo_q <= tmo_q + 1'b1;
   end

   // Fires in the last of TIMEOUT_CYCLES WAIT cycles.
   assign tmo_hit = (state_q == S_WAIT) &&
                    (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_tmo = TIMEOUT_CYCLES;

   assign tmo_hit = 1'b0;
`endif

   assign op_end = done_i | err_i | tmo_hit;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (gnt_found)   state_d = S_ISSUE;
         S_ISSUE: if (cmd_ready_i) state_d = S_WAIT;
         S_WAIT:  if (op_end)      state_d = S_RESP;
         S_RESP:                   state_d = S_IDLE;
         default:                  state_d = S_IDLE;
      endcase
   end

   // Captured grant context and the rotating pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q  <= '0;
         id_q  <= '0;
         cmd_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE && gnt_found) begin
            rr_q  <= rr_nxt;
            id_q  <= gnt_idx;
            cmd_q <= req_cmd_i[gnt_idx*CMD_W +: CMD_W];
         end
         if (state_q == S_WAIT) begin
            if (done_i || err_i)
               err_q <= err_i;
            else if (tmo_hit)
               err_q <= 1'b1;
         end
      end
   end

   // Output logic; accept is masked during reset so nothing leaks out.
   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      rsp_err_o   = 1'b0;
      cmd_valid_o = 1'b0;
      busy_o      = (state_q != S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            if (gnt_found && !rst)
               req_ready_o[gnt_idx] = 1'b1;
         end
         S_ISSUE: cmd_valid_o = 1'b1;
         S_WAIT:  ;
         S_RESP: begin
            rsp_valid_o[id_q] = 1'b1;
            rsp_err_o         = err_q;
         end
         default: ;
      endcase
   end

   assign cmd_o      = cmd_q;
   assign grant_id_o = id_q;

endmodule

// File: tb/tb_ctrl_sched.sv
// tb_ctrl_sched: directed bench for ctrl_sched with a response scoreboard.
// Expected responses are queued at grant time and popped on rsp_valid_o.
`timescale 1ns/1ps
module tb_ctrl_sched;

   localparam int N   = 4;
   localparam int CW  = 8;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid_i;
   logic [N*CW-1:0] req_cmd_i;
   logic [N-1:0]  req_ready_o;
   logic [N-1:0]  rsp_valid_o;
   logic          rsp_err_o;
   logic          cmd_valid_o;
   logic [CW-1:0] cmd_o;
   logic          cmd_ready_i;
   logic          done_i;
   logic          err_i;
   logic          busy_o;
   logic [1:0]    grant_id_o;

   int errors = 0;
   int checks = 0;
   int sb[$];
   logic [CW-1:0] cmd_tab [N];

   ctrl_sched #(
      .N_REQ(N),
      .CMD_W(CW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid_i(req_valid_i),
      .req_cmd_i(req_cmd_i),
      .req_ready_o(req_ready_o),
      .rsp_valid_o(rsp_valid_o),
      .rsp_err_o(rsp_err_o),
      .cmd_valid_o(cmd_valid_o),
      .cmd_o(cmd_o),
      .cmd_ready_i(cmd_ready_i),
      .done_i(done_i),
      .err_i(err_i),
      .busy_o(busy_o),
      .grant_id_o(grant_id_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every response must match the oldest queued grant.
   always @(negedge clk) begin : mon
      int e;
      if (!rst && rsp_valid_o != '0) begin
         if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_rsp_id", 32'(rsp_valid_o), 32'(1 << (e / 2)));
            chk("sb_rsp_err", 32'(rsp_err_o), 32'(e % 2));
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full operation; req_valid_i held until RESP to check gating.
   task automatic op(input logic [3:0] vm, input int g, input int stall,
                     input logic dn, input logic er);
      req_valid_i = vm;
      cmd_ready_i = 1'b0;
      @(negedge clk);
      chk("grant", 32'(req_ready_o), 32'(1 << g));
      chk("idle_busy", 32'(busy_o), 32'd0);
      sb.push_back(g * 2 + int'(er));
      step();
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("bp_valid", 32'(cmd_valid_o), 32'd1);
         chk("bp_cmd", 32'(cmd_o), 32'(cmd_tab[g]));
         chk("bp_ready", 32'(req_ready_o), 32'd0);
         step();
      end
      cmd_ready_i = 1'b1;
      @(negedge clk);
      chk("issue_valid", 32'(cmd_valid_o), 32'd1);
      chk("issue_cmd", 32'(cmd_o), 32'(cmd_tab[g]));
      chk("grant_id", 32'(grant_id_o), 32'(g));
      step();
      cmd_ready_i = 1'b0;
      done_i = dn;
      err_i  = er;
      @(negedge clk);
      chk("wait_busy", 32'(busy_o), 32'd1);
      chk("wait_no_rsp", 32'(rsp_valid_o), 32'd0);
      step();
      done_i = 1'b0;
      err_i  = 1'b0;
      @(negedge clk);
      chk("rsp_vec", 32'(rsp_valid_o), 32'(1 << g));
      chk("rsp_err", 32'(rsp_err_o), 32'(er));
      chk("rsp_no_grant", 32'(req_ready_o), 32'd0);
      step();
      req_valid_i = '0;
   endtask

   initial begin
      cmd_tab[0] = 8'h10;
      cmd_tab[1] = 8'h21;
      cmd_tab[2] = 8'hA5;
      cmd_tab[3] = 8'h3C;
      for (int k = 0; k < N; k++)
         req_cmd_i[k*CW +: CW] = cmd_tab[k];
      rst         = 1'b1;
      req_valid_i = 4'b1111;
      cmd_ready_i = 1'b0;
      done_i      = 1'b0;
      err_i       = 1'b0;

      // Reset with all requesters asserting.
      repeat (3) step();
      @(negedge clk);
      chk("rst_ready", 32'(req_ready_o), 32'd0);
      chk("rst_rsp", 32'(rsp_valid_o), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
      chk("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
      chk("rst_cmd", 32'(cmd_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_gid", 32'(grant_id_o), 32'd0);
      step();
      rst = 1'b0;

      // First grant after reset goes to requester 0.
      op(4'b1111, 0, 0, 1'b1, 1'b0);
      // Single op from requester 2.
      op(4'b0100, 2, 0, 1'b1, 1'b0);
      // done and err together, then err alone.
      op(4'b0010, 1, 0, 1'b1, 1'b1);
      op(4'b0001, 0, 0, 1'b0, 1'b1);

      // Stray flags in IDLE produce nothing.
      done_i = 1'b1;
      err_i  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stray_busy", 32'(busy_o), 32'd0);
         chk("stray_rsp", 32'(rsp_valid_o), 32'd0);
         step();
      end
      done_i = 1'b0;
      err_i  = 1'b0;

      // Backpressure: rr_ptr now 1.
      op(4'b1111, 1, 5, 1'b1, 1'b0);

      // Reset while in WAIT: response abandoned.
      req_valid_i = 4'b1000;
      @(negedge clk);
      chk("rw_grant", 32'(req_ready_o), 32'b1000);
      step();
      req_valid_i = '0;
      cmd_ready_i = 1'b1;
      step();
      cmd_ready_i = 1'b0;
      @(negedge clk);
      chk("rw_wait_busy", 32'(busy_o), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rw_busy", 32'(busy_o), 32'd0);
      chk("rw_gid", 32'(grant_id_o), 32'd0);
      done_i = 1'b1;
      repeat (2) step();
      done_i = 1'b0;
      rst    = 1'b0;
      @(negedge clk);
      chk("rw_no_rsp", 32'(rsp_valid_o), 32'd0);
      step();

      // Fairness from a fresh pointer.
      op(4'b1111, 0, 0, 1'b1, 1'b0);
      op(4'b1111, 1, 0, 1'b1, 1'b0);
      op(4'b1111, 2, 0, 1'b1, 1'b0);
      op(4'b1111, 3, 0, 1'b1, 1'b0);
      op(4'b1111, 0, 0, 1'b1, 1'b0);

      // Datapath never answers.
      req_valid_i = 4'b0100;
      @(negedge clk);
      chk("to_grant", 32'(req_ready_o), 32'b0100);
      step();
      req_valid_i = '0;
      cmd_ready_i = 1'b1;
      step();
      cmd_ready_i = 1'b0;
`ifdef CTRL_SCHED_TIMEOUT_EN
      sb.push_back(2 * 2 + 1);
      for (int c = 0; c < TMO; c++) begin
         @(negedge clk);
         chk("to_wait_busy", 32'(busy_o), 32'd1);
         chk("to_wait_rsp", 32'(rsp_valid_o), 32'd0);
         step();
      end
      @(negedge clk);
      chk("to_rsp", 32'(rsp_valid_o), 32'b0100);
      chk("to_rsp_err", 32'(rsp_err_o), 32'd1);
      step();
      done_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("to_late_busy", 32'(busy_o), 32'd0);
         step();
      end
      done_i = 1'b0;
`else
      repeat (2000) step();
      @(negedge clk);
      chk("hang_busy", 32'(busy_o), 32'd1);
      chk("hang_rsp", 32'(rsp_valid_o), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("hang_rst_busy", 32'(busy_o), 32'd0);
`endif
      repeat (2) step();
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
